div_sequencer: RTL

- Multi-cycle controller for the RV64 M-extension divide/remainder ops: DIV, DIVU, REM, REMU and the W variants.
- Sequences a single shared restoring subtract/shift datapath, producing one quotient bit per cycle.
- Sits beside the ALU in EX. The pipeline stalls on busy and captures result on valid.

---
 rtl/div_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle RV64 M-extension divider/remainder sequencer (restoring, one quotient bit per cycle).
// Latency: N+1 cycles from accepted start to valid (N = XLEN, or XLEN/2 for W ops); 1 cycle for div-by-zero/overflow.
// Backpressure: start is only accepted while ready_o=1; flush_i aborts any state and drops a same-cycle start.
module div_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            rem_op_q, word_q, qneg_q, rneg_q;
  logic [XLEN-1:0] divisor_q, quo_q, rem_q, result_q;
  logic [CW-1:0]   count_q;

  logic            sgn_op, rem_op, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, quo_init, special_res;
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt, calc_res;
  logic            accept, step, load_special, load_calc;

  // Apply the sign correction, then sign-extend bit HALF-1 for every W op (unsigned included).
  function automatic logic [XLEN-1:0] finish_res(input logic [XLEN-1:0] raw,
                                                 input logic neg, input logic w);
    logic [XLEN-1:0] v;
    v = neg ? -raw : raw;
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // Operand prep: width/sign extension, magnitudes and special-case detection for the incoming request.
  always_comb begin
    sgn_op = (func3_i == 3'b100) || (func3_i == 3'b110);
    rem_op = func3_i[2] & func3_i[1];
    a_ext  = rs1_i;
    b_ext  = rs2_i;
    if (word_i) begin
      a_ext = sgn_op ? {{HALF{rs1_i[HALF-1]}}, rs1_i[HALF-1:0]} : {{HALF{1'b0}}, rs1_i[HALF-1:0]};
      b_ext = sgn_op ? {{HALF{rs2_i[HALF-1]}}, rs2_i[HALF-1:0]} : {{HALF{1'b0}}, rs2_i[HALF-1:0]};
    end
    a_neg    = sgn_op & a_ext[XLEN-1];
    b_neg    = sgn_op & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    // W dividends sit in the upper half so the first HALF shifts consume exactly their bits.
    quo_init = word_i ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
    div_zero = (b_ext == '0);
    ovf      = sgn_op && (b_ext == '1) &&
               (a_ext == (word_i ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                 : {1'b1, {(XLEN-1){1'b0}}}));
    special  = div_zero | ovf;
    if (div_zero) begin
      special_res = finish_res(rem_op ? a_ext : '1, 1'b0, word_i);
    end else begin
      special_res = finish_res(rem_op ? '0 : a_ext, 1'b0, word_i);
    end
  end

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    ge       = (rem_sh >= {1'b0, divisor_q});
    rem_nxt  = ge ? (rem_sh[XLEN-1:0] - divisor_q) : rem_sh[XLEN-1:0];
    quo_nxt  = {quo_q[XLEN-2:0], ge};
    calc_res = finish_res(rem_op_q ? rem_nxt : quo_nxt, rem_op_q ? rneg_q : qneg_q, word_q);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath control; flush overrides everything, including a same-cycle start.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    step         = 1'b0;
    load_special = 1'b0;
    load_calc    = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        accept       = 1'b1;
        load_special = special;
        state_d      = special ? DONE : CALC;
      end
      CALC: begin
        step = 1'b1;
        if (count_q == CW'(1)) begin
          load_calc = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d      = IDLE;
      accept       = 1'b0;
      step         = 1'b0;
      load_special = 1'b0;
      load_calc    = 1'b0;
    end
  end

  // Operand latch, iteration registers and the held result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_op_q  <= 1'b0;
      word_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        rem_op_q  <= rem_op;
        word_q    <= word_i;
        qneg_q    <= a_neg ^ b_neg;
        rneg_q    <= a_neg;
        divisor_q <= b_mag;
        quo_q     <= quo_init;
        rem_q     <= '0;
        count_q   <= word_i ? CW'(HALF) : CW'(XLEN);
      end else if (step) begin
        quo_q   <= quo_nxt;
        rem_q   <= rem_nxt;
        count_q <= count_q - CW'(1);
      end
      if (load_special)   result_q <= special_res;
      else if (load_calc) result_q <= calc_res;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == CALC);
  assign valid_o  = (state_q == DONE) && !flush_i;
  assign result_o = result_q;

endmodule
